// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-execution bundle: condition field, flag/write requests, gated strobes and flag state.
interface cond_logic_if #(
    parameter int CNT_WIDTH = 16
);
    logic [3:0]           Cond;
    logic [3:0]           ALUFlags;
    logic [1:0]           FlagW;
    logic                 PCS;
    logic                 RegW;
    logic                 MemW;
    logic                 Stall;
    logic                 PCSrc;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 CondEx;
    logic [3:0]           Flags;
    logic [CNT_WIDTH-1:0] TakenCount;
    logic [CNT_WIDTH-1:0] AnnulCount;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, TakenCount, AnnulCount
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, TakenCount, AnnulCount
    );
endinterface

// File: rtl/cond_logic.sv
// ARM conditional-execution stage: NZCV register, condition evaluation and write-strobe gating.
// Optional saturating taken/annul counters are built when COND_PERF_CNT_EN is defined.
module cond_logic #(
    parameter int CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_s;
    logic       update_ok_s;
    logic       strobe_ok_s;

    // Condition check uses only registered flags, never the current ALU result.
    always_comb begin
        cond_ex_s   = cond_pass(bus.Cond, flags_q);
        update_ok_s = cond_ex_s & ~bus.Stall;
        strobe_ok_s = update_ok_s & ~reset;
    end

    // N,Z and C,V halves are written independently.
    always_comb begin
        flags_d = flags_q;
        if (update_ok_s && bus.FlagW[1]) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (update_ok_s && bus.FlagW[0]) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
    end

    // Flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.CondEx   = cond_ex_s;
    assign bus.Flags    = flags_q;
    assign bus.PCSrc    = bus.PCS  & strobe_ok_s;
    assign bus.RegWrite = bus.RegW & strobe_ok_s;
    assign bus.MemWrite = bus.MemW & strobe_ok_s;

`ifdef COND_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] taken_q, taken_d;
    logic [CNT_WIDTH-1:0] annul_q, annul_d;
    logic                 annul_ev_s;

    // Saturating counters; an annul is any failed instruction that requested a side effect.
    always_comb begin
        annul_ev_s = ~cond_ex_s & ~bus.Stall &
                     (bus.PCS | bus.RegW | bus.MemW | (bus.FlagW != 2'b00));
        taken_d = taken_q;
        annul_d = annul_q;
        if (bus.PCSrc && (taken_q != {CNT_WIDTH{1'b1}})) begin
            taken_d = taken_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            taken_d = taken_q;
        end
        if (annul_ev_s && (annul_q != {CNT_WIDTH{1'b1}})) begin
            annul_d = annul_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            annul_d = annul_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q <= {CNT_WIDTH{1'b0}};
            annul_q <= {CNT_WIDTH{1'b0}};
        end else begin
            taken_q <= taken_d;
            annul_q <= annul_d;
        end
    end

    assign bus.TakenCount = taken_q;
    assign bus.AnnulCount = annul_q;
`else
    assign bus.TakenCount = {CNT_WIDTH{1'b0}};
    assign bus.AnnulCount = {CNT_WIDTH{1'b0}};
`endif

endmodule
